// File: rtl/sfm_in_stage.sv
// Input conditioning stage for the softmax datapath: byte strobes -> element strobes,
// tail masking against the job length, last-beat marking, and a small output buffer.
// Latency: one cycle minimum from an accepted beat to valid. ready is low when the buffer is full.
//
// Ports:
//   clk_i, rst_ni, clear_i      clock, synchronous active-low reset, synchronous flush
//   start_i, len_i              job start (honoured only in IDLE) and element count
//   valid_i/ready_o/data_i/strb_i   upstream stream with byte strobes
//   valid_o/ready_i/data_o/strb_o/last_o   downstream stream with per-element strobes
//   busy_o, done_o, count_o     job status, completion pulse, emitted element count
module sfm_in_stage #(
  parameter int DATA_WIDTH = 128,
  parameter int ELEM_WIDTH = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             start_i,
  input  logic [LEN_WIDTH-1:0]             len_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [DATA_WIDTH-1:0]            data_i,
  input  logic [DATA_WIDTH/8-1:0]          strb_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic [DATA_WIDTH/ELEM_WIDTH-1:0] strb_o,
  output logic                             last_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [LEN_WIDTH-1:0]             count_o
);

  localparam int VECT_WIDTH     = DATA_WIDTH / ELEM_WIDTH;
  localparam int BYTES_PER_ELEM = ELEM_WIDTH / 8;
  localparam int CNT_W          = $clog2(VECT_WIDTH + 1);
  localparam int PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W          = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;

  // Buffer storage; each entry also carries how many in-range elements it holds
  // so the element count can be advanced when the beat leaves.
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [VECT_WIDTH-1:0] mem_strb [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [CNT_W-1:0]      mem_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [VECT_WIDTH-1:0] push_strb;
  logic                  push_last;
  logic [LEN_WIDTH-1:0]  push_take;
  logic [LEN_WIDTH-1:0]  vect_len;
  logic [LEN_WIDTH:0]    count_sum;

  assign vect_len   = LEN_WIDTH'(VECT_WIDTH);
  assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);

  assign ready_o = (state == RUN) && !fifo_full;
  assign valid_o = !fifo_empty;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // An element is valid only if all of its bytes are strobed and it lies
  // within the remaining job length (positions count regardless of strobes).
  always_comb begin
    push_strb = '0;
    for (int i = 0; i < VECT_WIDTH; i++) begin
      push_strb[i] = (&strb_i[i*BYTES_PER_ELEM +: BYTES_PER_ELEM]) &&
                     (LEN_WIDTH'(i) < remaining);
    end
  end

  assign push_last = (remaining <= vect_len);
  assign push_take = push_last ? remaining : vect_len;

  assign data_o = mem_data[rd_ptr];
  assign strb_o = valid_o ? mem_strb[rd_ptr] : '0;
  assign last_o = valid_o && mem_last[rd_ptr];

  assign count_sum = {1'b0, count_o} + (LEN_WIDTH+1)'(mem_cnt[rd_ptr]);

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= data_i;
      mem_strb[wr_ptr] <= push_strb;
      mem_last[wr_ptr] <= push_last;
      mem_cnt[wr_ptr]  <= CNT_W'(push_take);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state     <= IDLE;
      remaining <= '0;
      count_o   <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else begin
      done_o <= 1'b0;

      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
        count_o <= count_sum[LEN_WIDTH] ? '1 : count_sum[LEN_WIDTH-1:0];
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase

      case (state)
        IDLE: begin
          if (start_i) begin
            count_o <= '0;
            if (len_i != '0) begin
              remaining <= len_i;
              state     <= RUN;
              busy_o    <= 1'b1;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push) begin
            remaining <= remaining - push_take;
            if (push_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && mem_last[rd_ptr]) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfm_in_stage.sv
module tb_sfm_in_stage;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         start;
  logic [31:0]  len;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] data_in;
  logic [15:0]  strb_in;
  logic         valid_out;
  logic         ready_in;
  logic [127:0] data_out;
  logic [7:0]   strb_out;
  logic         last_out;
  logic         busy;
  logic         done;
  logic [31:0]  count;

  sfm_in_stage #(
    .DATA_WIDTH(128), .ELEM_WIDTH(16), .FIFO_DEPTH(2), .LEN_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .len_i(len),
    .valid_i(valid_in), .ready_o(ready_out), .data_i(data_in), .strb_i(strb_in),
    .valid_o(valid_out), .ready_i(ready_in), .data_o(data_out), .strb_o(strb_out),
    .last_o(last_out), .busy_o(busy), .done_o(done), .count_o(count)
  );

  typedef struct {
    logic [127:0] data;
    logic [7:0]   strb;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  bit           done_pend = 0;
  int           done_cyc = 0;
  bit           prev_hold = 0;
  logic [127:0] prev_data;
  logic [7:0]   prev_strb;
  logic         prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, hold stability under backpressure, done timing.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_expected", done_pend, 1);
      if (done_pend) check("done_timing", cyc, done_cyc);
      check("busy_low_at_done", busy, 0);
      done_pend = 0;
    end
    if (prev_hold && valid_out) begin
      check("hold_data", data_out, prev_data);
      check("hold_strb", strb_out, prev_strb);
      check("hold_last", last_out, prev_last);
    end
    prev_hold = valid_out && !ready_in;
    prev_data = data_out;
    prev_strb = strb_out;
    prev_last = last_out;
    if (valid_out && ready_in) begin
      check("beat_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("out_data", data_out, e.data);
        check("out_strb", strb_out, e.strb);
        check("out_last", last_out, e.last);
        if (e.last) begin
          done_pend = 1;
          done_cyc  = cyc + 1;
        end
      end
    end
  end

  // All tasks start and end at posedge + 1.
  task automatic start_job(input logic [31:0] l);
    start = 1'b1;
    len   = l;
    if (l == 0) begin
      done_pend = 1;
      done_cyc  = cyc + 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] s,
                           input logic [7:0] es, input logic el);
    bit acc = 0;
    valid_in = 1'b1;
    data_in  = d;
    strb_in  = s;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready_out) begin
        acc = 1;
        break;
      end
    end
    if (acc) exp_q.push_back('{d, es, el});
    else check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int d0, input logic [31:0] exp_count, input string name);
    for (int k = 0; k < 200 && done_cnt == d0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_count"}, count, exp_count);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_idle"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    bit bad;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; len = '0;
    valid_in = 1'b0; data_in = '0; strb_in = '0; ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", last_out, 0);
    check("rst_count", count, 0);
    @(posedge clk); #1;

    // Full vector: two full beats
    ready_in = 1'b1;
    d0 = done_cnt;
    start_job(16);
    @(negedge clk);
    check("full_busy", busy, 1);
    @(posedge clk); #1;
    send_beat(128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 16'hFFFF, 8'hFF, 1'b0);
    send_beat(128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff, 16'hFFFF, 8'hFF, 1'b1);
    wait_done(d0, 16, "full");

    // Tail mask: 13 elements -> 8 + 5
    d0 = done_cnt;
    start_job(13);
    send_beat(128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'hFFFF, 8'hFF, 1'b0);
    send_beat(128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000, 16'hFFFF, 8'h1F, 1'b1);
    valid_in = 1'b1;
    data_in  = 128'hdead_beef;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      bad |= ready_out;
    end
    check("tail_no_third_beat", bad, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_done(d0, 13, "tail");

    // Partial byte strobe: element 0 loses byte 1
    d0 = done_cnt;
    start_job(8);
    send_beat(128'h0a0a_0b0b_0c0c_0d0d_0e0e_0f0f_1010_1212, 16'hFFFD, 8'hFE, 1'b1);
    wait_done(d0, 8, "partial");

    // Backpressure: two beats fill the buffer, the third stalls
    d0 = done_cnt;
    ready_in = 1'b0;
    start_job(32);
    send_beat(128'hA0, 16'hFFFF, 8'hFF, 1'b0);
    send_beat(128'hA1, 16'hFFFF, 8'hFF, 1'b0);
    fork
      begin
        send_beat(128'hA2, 16'hFFFF, 8'hFF, 1'b0);
        send_beat(128'hA3, 16'hFFFF, 8'hFF, 1'b1);
      end
      begin
        bad = 0;
        repeat (4) begin
          @(negedge clk);
          bad |= ready_out | !valid_out;
        end
        check("bp_ready_low_valid_high", bad, 0);
        @(posedge clk); #1;
        ready_in = 1'b1;
      end
    join
    wait_done(d0, 32, "bp");

    // Zero length
    d0 = done_cnt;
    start_job(0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      bad |= busy | valid_out | ready_out;
    end
    check("zero_quiet", bad, 0);
    check("zero_done_once", done_cnt - d0, 1);
    check("zero_count", count, 0);
    @(posedge clk); #1;

    // Abort mid-job with clear
    ready_in = 1'b0;
    d0 = done_cnt;
    start_job(32);
    send_beat(128'hB0, 16'hFFFF, 8'hFF, 1'b0);
    clear = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("abort_valid", valid_out, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready_out, 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    ready_in = 1'b1;
    d0 = done_cnt;
    start_job(8);
    send_beat(128'hC0C1_C2C3, 16'hFFFF, 8'hFF, 1'b1);
    wait_done(d0, 8, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
